dmem_arbiter: RTL and testbench

Single-port data-memory arbiter placed between the MEM pipeline stage and the 2048-word data memory, sharing that memory with a secondary debug/loader requester. It issues at most one access per cycle, stalls the pipeline when the debug port wins, and bounds debug starvation with a counter. It also supports an exclusive debug lock and suppresses out-of-range accesses. Read data is returned to the winning requester one cycle after issue.

---
 rtl/dmem_arbiter_if.sv | 52 +++++
 rtl/dmem_arbiter.sv | 121 ++++++++++++
 tb/tb_dmem_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage, the debug/loader port, the data memory
// and the arbiter. The arbiter connects through the slave modport; the
// requesters and the memory model sit on the master side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              p_req;
    logic              p_we;
    logic [31:0]       p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic              p_stall;
    logic [DATA_W-1:0] p_rdata;
    logic              p_rvalid;

    logic              d_req;
    logic              d_we;
    logic              d_lock;
    logic [31:0]       d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic [DATA_W-1:0] d_rdata;
    logic              d_rvalid;

    logic              err;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata,
        output p_stall, p_rdata, p_rvalid,
        input  d_req, d_we, d_lock, d_addr, d_wdata,
        output d_gnt, d_rdata, d_rvalid,
        output err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata,
        input  p_stall, p_rdata, p_rvalid,
        output d_req, d_we, d_lock, d_addr, d_wdata,
        input  d_gnt, d_rdata, d_rvalid,
        input  err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: pipeline has priority, debug is granted
// when the pipeline is idle, when it has waited STARVE_MAX cycles, or
// exclusively while it holds the lock. Out-of-range accesses are accepted
// but never reach the memory; they raise err and read back as zero.
module dmem_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic {ARB, LOCKED} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state, state_nxt;
    logic [3:0]  starve_cnt, starve_nxt;
    logic        p_gnt, d_gnt_i, any_gnt;
    logic        p_oor, d_oor;
    logic        win_we, win_oor;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // return tag for the access issued last cycle
    logic        tag_vld, tag_dbg, tag_rd, tag_oor;
    logic [DATA_W-1:0] ret_data;

    function automatic logic out_of_range(input logic [31:0] a);
        return (a[31:ADDR_W+2] != '0) || (a[1:0] != 2'b00);
    endfunction

    assign p_oor = out_of_range(bus.p_addr);
    assign d_oor = out_of_range(bus.d_addr);

    // Arbitration, lock transitions and starvation counter update
    always_comb begin
        state_nxt  = state;
        p_gnt      = 1'b0;
        d_gnt_i    = 1'b0;
        case (state)
            ARB: begin
                if (bus.d_req && (starve_cnt == STARVE_LIM))
                    d_gnt_i = 1'b1;
                else if (bus.p_req)
                    p_gnt = 1'b1;
                else if (bus.d_req)
                    d_gnt_i = 1'b1;
                if (d_gnt_i && bus.d_lock)
                    state_nxt = LOCKED;
            end
            LOCKED: begin
                d_gnt_i = bus.d_req;
                if (!bus.d_lock)
                    state_nxt = ARB;
            end
            default: state_nxt = ARB;
        endcase

        if (d_gnt_i || !bus.d_req)
            starve_nxt = 4'd0;
        else if (starve_cnt != STARVE_LIM)
            starve_nxt = starve_cnt + 4'd1;
        else
            starve_nxt = starve_cnt;
    end

    // Winner mux onto the memory port; everything idles at zero without a grant
    always_comb begin
        win_we    = 1'b0;
        win_oor   = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        if (p_gnt) begin
            win_we    = bus.p_we;
            win_oor   = p_oor;
            win_addr  = bus.p_addr[ADDR_W+1:2];
            win_wdata = bus.p_wdata;
        end else if (d_gnt_i) begin
            win_we    = bus.d_we;
            win_oor   = d_oor;
            win_addr  = bus.d_addr[ADDR_W+1:2];
            win_wdata = bus.d_wdata;
        end
    end

    assign any_gnt       = p_gnt | d_gnt_i;
    assign bus.p_stall   = bus.p_req & ~p_gnt;
    assign bus.d_gnt     = d_gnt_i;
    assign bus.mem_en    = any_gnt & ~win_oor & reset;
    assign bus.mem_we    = win_we;
    assign bus.mem_addr  = win_addr;
    assign bus.mem_wdata = win_wdata;

    // State, starvation counter and return tag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ARB;
            starve_cnt <= 4'd0;
            tag_vld    <= 1'b0;
            tag_dbg    <= 1'b0;
            tag_rd     <= 1'b0;
            tag_oor    <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            tag_vld    <= any_gnt;
            tag_dbg    <= d_gnt_i;
            tag_rd     <= any_gnt & ~win_we;
            tag_oor    <= win_oor;
        end
    end

    assign ret_data     = tag_oor ? '0 : bus.mem_rdata;
    assign bus.p_rvalid = tag_vld & tag_rd & ~tag_dbg;
    assign bus.d_rvalid = tag_vld & tag_rd & tag_dbg;
    assign bus.p_rdata  = bus.p_rvalid ? ret_data : '0;
    assign bus.d_rdata  = bus.d_rvalid ? ret_data : '0;
    assign bus.err      = tag_vld & tag_oor;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table of per-cycle requests with expected grant and
// memory-strobe values, plus the return expected one cycle later, which is
// queued and checked when the DUT produces it. Hand-written reset sequences
// follow the table.
module tb_dmem_arbiter;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam logic [31:0] DB = 32'hDEADBEEF;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous single-port memory model
    logic [31:0] mem [0:2047];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    typedef struct {
        logic        pr, pw;
        logic [31:0] pa, pd;
        logic        dr, dw, dl;
        logic [31:0] da, dd;
        logic        es, eg, em;
        logic [10:0] ema;
        logic        prv;
        logic [31:0] prd;
        logic        drv;
        logic [31:0] drd;
        logic        er;
    } vec_t;

    typedef struct {
        logic        prv;
        logic [31:0] prd;
        logic        drv;
        logic [31:0] drd;
        logic        er;
    } ret_t;

    vec_t vecs [21];
    ret_t sb [$];

    function automatic vec_t mk(
        input logic pr, pw, input logic [31:0] pa, pd,
        input logic dr, dw, dl, input logic [31:0] da, dd,
        input logic es, eg, em, input logic [10:0] ema,
        input logic prv, input logic [31:0] prd,
        input logic drv, input logic [31:0] drd, input logic er);
        vec_t v;
        v.pr = pr; v.pw = pw; v.pa = pa; v.pd = pd;
        v.dr = dr; v.dw = dw; v.dl = dl; v.da = da; v.dd = dd;
        v.es = es; v.eg = eg; v.em = em; v.ema = ema;
        v.prv = prv; v.prd = prd; v.drv = drv; v.drd = drd; v.er = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.p_req = v.pr; bus.p_we = v.pw; bus.p_addr = v.pa; bus.p_wdata = v.pd;
        bus.d_req = v.dr; bus.d_we = v.dw; bus.d_lock = v.dl;
        bus.d_addr = v.da; bus.d_wdata = v.dd;
    endtask

    // compare the oldest queued return against the DUT's return outputs
    task automatic check_ret(input string tag);
        ret_t r;
        if (sb.size() == 0) return;
        r = sb.pop_front();
        chk({tag, " p_rvalid"}, 32'(bus.p_rvalid), 32'(r.prv));
        chk({tag, " p_rdata"},  bus.p_rdata,       r.prd);
        chk({tag, " d_rvalid"}, 32'(bus.d_rvalid), 32'(r.drv));
        chk({tag, " d_rdata"},  bus.d_rdata,       r.drd);
        chk({tag, " err"},      32'(bus.err),      32'(r.er));
    endtask

    task automatic step(input int i);
        vec_t v;
        ret_t r;
        string tag;
        v = vecs[i];
        @(negedge clk);
        check_ret($sformatf("v%0d-ret", i - 1));
        drive(v);
        #1;
        tag = $sformatf("v%0d", i);
        chk({tag, " p_stall"},  32'(bus.p_stall),  32'(v.es));
        chk({tag, " d_gnt"},    32'(bus.d_gnt),    32'(v.eg));
        chk({tag, " mem_en"},   32'(bus.mem_en),   32'(v.em));
        chk({tag, " mem_addr"}, 32'(bus.mem_addr), 32'(v.ema));
        r.prv = v.prv; r.prd = v.prd; r.drv = v.drv; r.drd = v.drd; r.er = v.er;
        sb.push_back(r);
    endtask

    initial begin
        //              pr pw pa       pd     dr dw dl da      dd       es eg em ema    prv prd      drv drd     er
        vecs[0]  = mk(0, 0, 0,       0,     0, 0, 0, 0,      0,       0, 0, 0, 0,     0, 0,       0, 0,      0);
        vecs[1]  = mk(1, 1, 'h10,    DB,    0, 0, 0, 0,      0,       0, 0, 1, 4,     0, 0,       0, 0,      0);
        vecs[2]  = mk(1, 0, 'h10,    0,     0, 0, 0, 0,      0,       0, 0, 1, 4,     1, DB,      0, 0,      0);
        vecs[3]  = mk(0, 0, 0,       0,     1, 1, 0, 'h8,    'h1234,  0, 1, 1, 2,     0, 0,       0, 0,      0);
        vecs[4]  = mk(1, 0, 'h8,     0,     0, 0, 0, 0,      0,       0, 0, 1, 2,     1, 'h1234,  0, 0,      0);
        vecs[5]  = mk(1, 0, 'h2000,  0,     0, 0, 0, 0,      0,       0, 0, 0, 0,     1, 0,       0, 0,      1);
        vecs[6]  = mk(0, 0, 0,       0,     1, 0, 0, 'h41,   0,       0, 1, 0, 'h10,  0, 0,       1, 0,      1);
        vecs[7]  = mk(1, 1, 'h20,    'h55,  0, 0, 0, 0,      0,       0, 0, 1, 8,     0, 0,       0, 0,      0);
        vecs[8]  = mk(0, 0, 0,       0,     1, 0, 0, 'h20,   0,       0, 1, 1, 8,     0, 0,       1, 'h55,   0);
        for (int k = 9; k <= 12; k++)
            vecs[k] = mk(1, 0, 'h10, 0,     1, 0, 0, 'h20,   0,       0, 0, 1, 4,     1, DB,      0, 0,      0);
        vecs[13] = mk(1, 0, 'h10,    0,     1, 0, 0, 'h20,   0,       1, 1, 1, 8,     0, 0,       1, 'h55,   0);
        vecs[14] = mk(1, 0, 'h10,    0,     0, 0, 0, 0,      0,       0, 0, 1, 4,     1, DB,      0, 0,      0);
        vecs[15] = mk(0, 0, 0,       0,     1, 1, 1, 'h40,   'hA5,    0, 1, 1, 16,    0, 0,       0, 0,      0);
        vecs[16] = mk(1, 0, 'h10,    0,     1, 0, 1, 'h40,   0,       1, 1, 1, 16,    0, 0,       1, 'hA5,   0);
        vecs[17] = mk(1, 0, 'h10,    0,     1, 0, 1, 'h40,   0,       1, 1, 1, 16,    0, 0,       1, 'hA5,   0);
        vecs[18] = mk(1, 0, 'h10,    0,     1, 0, 0, 'h40,   0,       1, 1, 1, 16,    0, 0,       1, 'hA5,   0);
        vecs[19] = mk(1, 0, 'h10,    0,     0, 0, 0, 0,      0,       0, 0, 1, 4,     1, DB,      0, 0,      0);
        vecs[20] = mk(0, 0, 0,       0,     0, 0, 0, 0,      0,       0, 0, 0, 0,     0, 0,       0, 0,      0);

        // reset values, with a pipeline request present during reset
        reset = 1'b0;
        drive(vecs[0]);
        bus.p_req = 1'b1; bus.p_addr = 32'h10;
        #1;
        chk("rst p_stall",  32'(bus.p_stall),  0);
        chk("rst mem_en",   32'(bus.mem_en),   0);
        chk("rst p_rvalid", 32'(bus.p_rvalid), 0);
        chk("rst d_rvalid", 32'(bus.d_rvalid), 0);
        chk("rst p_rdata",  bus.p_rdata,       0);
        chk("rst d_rdata",  bus.d_rdata,       0);
        chk("rst err",      32'(bus.err),      0);
        repeat (2) @(negedge clk);
        drive(vecs[0]);
        reset = 1'b1;

        for (int i = 0; i < 21; i++) step(i);
        @(negedge clk);
        check_ret("v20-ret");

        // lock a debug read, then reset before its data returns
        drive(vecs[0]);
        bus.d_req = 1'b1; bus.d_lock = 1'b1; bus.d_addr = 32'h40;
        #1;
        chk("mid d_gnt", 32'(bus.d_gnt), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("mid d_rvalid", 32'(bus.d_rvalid), 0);
        chk("mid mem_en",   32'(bus.mem_en),   0);
        @(negedge clk);
        chk("mid d_rvalid2", 32'(bus.d_rvalid), 0);
        drive(vecs[0]);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post starve_cnt", 32'(dut.starve_cnt), 0);
        // both sides request: an ARB state with a cleared counter lets the pipeline win
        bus.p_req = 1'b1; bus.p_addr = 32'h10;
        bus.d_req = 1'b1; bus.d_addr = 32'h20;
        #1;
        chk("post p_stall", 32'(bus.p_stall), 0);
        chk("post d_gnt",   32'(bus.d_gnt),   0);
        @(negedge clk);
        drive(vecs[0]);
        chk("post p_rvalid", 32'(bus.p_rvalid), 1);
        chk("post p_rdata",  bus.p_rdata,       DB);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
